// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/issue stage: instruction layout, opcodes,
// FSM states, the bubble encoding and source-usage helpers.
package pipe_pkg;

    localparam int         IMEM_DEPTH = 16;
    localparam int         IMEM_AW    = 4;
    localparam logic [4:0] PROG_MAX   = 5'(IMEM_DEPTH);

    localparam logic [3:0] NOP_RD   = 4'd0;
    localparam logic [7:0] NOP_ADDR = 8'hFF;

    localparam int FUNC_LSB = 20;
    localparam int RD_LSB   = 16;
    localparam int RS1_LSB  = 12;
    localparam int RS2_LSB  = 8;
    localparam int ADDR_LSB = 0;

    localparam logic [3:0] FN_ADD   = 4'd0;
    localparam logic [3:0] FN_SUB   = 4'd1;
    localparam logic [3:0] FN_AND   = 4'd2;
    localparam logic [3:0] FN_PASSA = 4'd3;
    localparam logic [3:0] FN_PASSB = 4'd4;
    localparam logic [3:0] FN_OR    = 4'd5;
    localparam logic [3:0] FN_XOR   = 4'd6;
    localparam logic [3:0] FN_NAND  = 4'd7;
    localparam logic [3:0] FN_NOTA  = 4'd8;
    localparam logic [3:0] FN_NOTB  = 4'd9;
    localparam logic [3:0] FN_SHR   = 4'd10;
    localparam logic [3:0] FN_SHL   = 4'd11;
    localparam logic [3:0] FN_HALT  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fetchState_e;

    typedef struct packed {
        logic [3:0] func;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] addr;
    } instr_t;

    // A bubble copies NOP_RD onto itself and stores to the reserved scratch address.
    localparam instr_t BUBBLE = '{func: FN_PASSA, rd: NOP_RD, rs1: NOP_RD,
                                  rs2: 4'd0, addr: NOP_ADDR};

    function automatic instr_t decodeWord(input logic [23:0] w);
        instr_t d;
        d.func = w[FUNC_LSB +: 4];
        d.rd   = w[RD_LSB   +: 4];
        d.rs1  = w[RS1_LSB  +: 4];
        d.rs2  = w[RS2_LSB  +: 4];
        d.addr = w[ADDR_LSB +: 8];
        return d;
    endfunction

    function automatic logic uses_rs1(input logic [3:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NAND,
            FN_PASSA, FN_NOTA, FN_SHR, FN_SHL: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [3:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NAND,
            FN_PASSB, FN_NOTB: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_fetch_if.sv
// Host-side control/load signals and the issue slot driven to the pipeline.
// stall_cnt exists only when PIPE_FETCH_STATS_EN is defined.
interface pipe_fetch_if;

    logic        load_en;
    logic [3:0]  load_addr;
    logic [23:0] load_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        halt;

    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic        issue_valid;
    logic        busy;
    logic        done;
    logic [4:0]  pc;
`ifdef PIPE_FETCH_STATS_EN
    logic [7:0]  stall_cnt;
`endif

    // master is the fetch stage itself; slave is the host that loads and starts it.
    modport master (
        input  load_en, load_addr, load_data, prog_len, start, halt,
`ifdef PIPE_FETCH_STATS_EN
        output stall_cnt,
`endif
        output rs1, rs2, rd, func, addr, issue_valid, busy, done, pc
    );

    modport slave (
        output load_en, load_addr, load_data, prog_len, start, halt,
`ifdef PIPE_FETCH_STATS_EN
        input  stall_cnt,
`endif
        input  rs1, rs2, rd, func, addr, issue_valid, busy, done, pc
    );

endinterface

// File: rtl/pipe_hazard_chk.sv
// Read-after-write check of the candidate instruction against the slot
// currently on the outputs; bubbles never cause a stall.
module pipe_hazard_chk
    import pipe_pkg::*;
(
    input  instr_t     cand_i,
    input  logic [3:0] prevRd_i,
    input  logic       prevValid_i,
    output logic       stall_o
);

    logic rs1Hit;
    logic rs2Hit;

    assign rs1Hit  = uses_rs1(cand_i.func) && (cand_i.rs1 == prevRd_i);
    assign rs2Hit  = uses_rs2(cand_i.func) && (cand_i.rs2 == prevRd_i);
    assign stall_o = prevValid_i && (rs1Hit || rs2Hit);

endmodule

// File: rtl/pipe_fetch.sv
// Fetch/issue stage: program buffer, PC sequencing FSM and hazard bubbles.
// Define PIPE_FETCH_STATS_EN to add the saturating stall_cnt output.
module pipe_fetch
    import pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    pipe_fetch_if.master  fetchBus
);

    instr_t      imem_q [IMEM_DEPTH];

    fetchState_e state_q, state_d;
    logic [4:0]  pc_q, pc_d;
    logic [4:0]  progLen_q, progLen_d;
    logic [1:0]  drainCnt_q, drainCnt_d;
    instr_t      slot_q, slot_d;
    logic        issueValid_q, issueValid_d;
    logic        done_q, done_d;

    instr_t      cand;
    logic        hazardStall;
    logic        haltOp;
    logic        countStall;
    logic        idleLike;
    logic        startAccept;
    logic        loadOk;
    logic [4:0]  pcNext;
    logic [4:0]  progLenClamped;

    assign idleLike       = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign loadOk         = fetchBus.load_en && idleLike;
    assign startAccept    = fetchBus.start && !fetchBus.halt && idleLike;
    assign cand           = imem_q[pc_q[IMEM_AW-1:0]];
    assign haltOp         = (cand.func == FN_HALT);
    assign pcNext         = pc_q + 5'd1;
    assign progLenClamped = (fetchBus.prog_len > PROG_MAX) ? PROG_MAX : fetchBus.prog_len;

    pipe_hazard_chk u_hazard (
        .cand_i      (cand),
        .prevRd_i    (slot_q.rd),
        .prevValid_i (issueValid_q),
        .stall_o     (hazardStall)
    );

    assign countStall = (state_q == ST_RUN) && !fetchBus.halt && !haltOp && hazardStall;

    // The buffer has no reset so a program survives an rst_n pulse.
    always_ff @(posedge clk) begin
        if (loadOk) begin
            imem_q[fetchBus.load_addr] <= decodeWord(fetchBus.load_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= 5'd0;
            progLen_q    <= 5'd0;
            drainCnt_q   <= 2'd0;
            slot_q       <= BUBBLE;
            issueValid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            progLen_q    <= progLen_d;
            drainCnt_q   <= drainCnt_d;
            slot_q       <= slot_d;
            issueValid_q <= issueValid_d;
            done_q       <= done_d;
        end
    end

    // Every slot defaults to a bubble; only a clean RUN fetch overrides it.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        progLen_d    = progLen_q;
        drainCnt_d   = drainCnt_q;
        slot_d       = BUBBLE;
        issueValid_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (startAccept) begin
                    pc_d       = 5'd0;
                    progLen_d  = progLenClamped;
                    drainCnt_d = 2'd0;
                    state_d    = (progLenClamped == 5'd0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (fetchBus.halt || haltOp) begin
                    state_d    = ST_DRAIN;
                    drainCnt_d = 2'd0;
                end else if (!countStall) begin
                    slot_d       = cand;
                    issueValid_d = 1'b1;
                    pc_d         = pcNext;
                    if (pcNext == progLen_q) begin
                        state_d    = ST_DRAIN;
                        drainCnt_d = 2'd0;
                    end
                end
            end
            ST_DRAIN: begin
                // Three bubbles go out, then done pulses on the edge entering DONE.
                if (drainCnt_q == 2'd3) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    drainCnt_d = drainCnt_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef PIPE_FETCH_STATS_EN
    logic [7:0] stallCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= 8'd0;
        end else if (startAccept) begin
            stallCnt_q <= 8'd0;
        end else if (countStall && (stallCnt_q != 8'hFF)) begin
            stallCnt_q <= stallCnt_q + 8'd1;
        end
    end

    assign fetchBus.stall_cnt = stallCnt_q;
`endif

    assign fetchBus.func        = slot_q.func;
    assign fetchBus.rd          = slot_q.rd;
    assign fetchBus.rs1         = slot_q.rs1;
    assign fetchBus.rs2         = slot_q.rs2;
    assign fetchBus.addr        = slot_q.addr;
    assign fetchBus.issue_valid = issueValid_q;
    assign fetchBus.busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign fetchBus.done        = done_q;
    assign fetchBus.pc          = pc_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: issue order, hazard bubbles, HALT, halt input,
// load protection, async reset and (with PIPE_FETCH_STATS_EN) stall counting.
module tb_pipe_fetch;

    typedef logic [24:0] slotQ_t [$];

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_fetch_if fetchBus();

    pipe_fetch dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetchBus (fetchBus)
    );

    // Slot vector layout: {func, rd, rs1, rs2, addr, issue_valid}.
    localparam logic [24:0] BUB = {4'd3, 4'd0, 4'd0, 4'd0, 8'hFF, 1'b0};

    logic [24:0] slotObs;
    assign slotObs = {fetchBus.func, fetchBus.rd, fetchBus.rs1, fetchBus.rs2,
                      fetchBus.addr, fetchBus.issue_valid};

    function automatic logic [23:0] mkInstr(input logic [3:0] f, input logic [3:0] d,
                                            input logic [3:0] s1, input logic [3:0] s2,
                                            input logic [7:0] a);
        return {f, d, s1, s2, a};
    endfunction

    function automatic logic [24:0] vec(input logic [23:0] w);
        return {w, 1'b1};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, pass a rising edge, then drop the pulse inputs.
    task automatic applyStimulus(input logic st, input logic hl, input logic ld,
                                 input logic [3:0] la, input logic [23:0] ldat,
                                 input logic [4:0] pl);
        fetchBus.start     = st;
        fetchBus.halt      = hl;
        fetchBus.load_en   = ld;
        fetchBus.load_addr = la;
        fetchBus.load_data = ldat;
        fetchBus.prog_len  = pl;
        @(posedge clk);
        #1;
        fetchBus.start   = 1'b0;
        fetchBus.halt    = 1'b0;
        fetchBus.load_en = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 5'd0);
    endtask

    task automatic loadWord(input logic [3:0] a, input logic [23:0] w);
        applyStimulus(1'b0, 1'b0, 1'b1, a, w, 5'd0);
    endtask

    task automatic runProgram(input string tag, input logic [4:0] pl, input slotQ_t expSlots);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 24'd0, pl);
        checkOutput({tag, " start"}, {slotObs, fetchBus.busy, fetchBus.pc}, {BUB, 1'b1, 5'd0});
        foreach (expSlots[i]) begin
            idle();
            checkOutput($sformatf("%s slot%0d", tag, i), {slotObs, fetchBus.done},
                        {expSlots[i], 1'b0});
        end
        idle();
        checkOutput({tag, " done pulse"}, {slotObs, fetchBus.done, fetchBus.busy},
                    {BUB, 1'b1, 1'b0});
        idle();
        checkOutput({tag, " done clear"}, {31'd0, fetchBus.done}, 32'd0);
    endtask

    logic [23:0] iAdd, iSub, iMov, iShl, iHalt, iOr, iXor, iAnd, iJunk;

    initial begin
        iAdd  = mkInstr(4'd0,  4'd3,  4'd1, 4'd2, 8'h10);
        iSub  = mkInstr(4'd1,  4'd4,  4'd5, 4'd6, 8'h11);
        iMov  = mkInstr(4'd3,  4'd7,  4'd3, 4'd0, 8'h12);
        iShl  = mkInstr(4'd11, 4'd8,  4'd2, 4'd3, 8'h13);
        iHalt = mkInstr(4'd15, 4'd0,  4'd0, 4'd0, 8'h00);
        iOr   = mkInstr(4'd5,  4'd9,  4'd1, 4'd2, 8'h14);
        iXor  = mkInstr(4'd6,  4'd10, 4'd5, 4'd6, 8'h15);
        iAnd  = mkInstr(4'd2,  4'd11, 4'd1, 4'd5, 8'h16);
        iJunk = mkInstr(4'd12, 4'd14, 4'd14, 4'd14, 8'h77);

        fetchBus.start     = 1'b0;
        fetchBus.halt      = 1'b0;
        fetchBus.load_en   = 1'b0;
        fetchBus.load_addr = 4'd0;
        fetchBus.load_data = 24'd0;
        fetchBus.prog_len  = 5'd0;
        rst_n = 1'b0;
        #12;
        checkOutput("reset slot", {7'd0, slotObs}, {7'd0, BUB});
        checkOutput("reset status", {fetchBus.busy, fetchBus.done, fetchBus.pc}, 7'd0);
`ifdef PIPE_FETCH_STATS_EN
        checkOutput("reset stall_cnt", {24'd0, fetchBus.stall_cnt}, 32'd0);
`endif
        #1 rst_n = 1'b1;

        $display("[TB] two independent instructions");
        loadWord(4'd0, iAdd);
        loadWord(4'd1, iSub);
        runProgram("indep", 5'd2, '{vec(iAdd), vec(iSub), BUB, BUB, BUB});

        $display("[TB] RAW hazard on rs1");
        loadWord(4'd1, iMov);
        runProgram("hazard", 5'd2, '{vec(iAdd), BUB, vec(iMov), BUB, BUB, BUB});
`ifdef PIPE_FETCH_STATS_EN
        checkOutput("hazard stall_cnt", {24'd0, fetchBus.stall_cnt}, 32'd1);
`endif

        $display("[TB] SHL ignores rs2");
        loadWord(4'd1, iShl);
        runProgram("shl", 5'd2, '{vec(iAdd), vec(iShl), BUB, BUB, BUB});
`ifdef PIPE_FETCH_STATS_EN
        checkOutput("shl stall_cnt", {24'd0, fetchBus.stall_cnt}, 32'd0);
`endif

        $display("[TB] HALT opcode");
        loadWord(4'd1, iHalt);
        loadWord(4'd2, iSub);
        runProgram("haltop", 5'd3, '{vec(iAdd), BUB, BUB, BUB, BUB});

        $display("[TB] halt input and load while busy");
        loadWord(4'd1, iSub);
        loadWord(4'd2, iOr);
        loadWord(4'd3, iXor);
        loadWord(4'd4, iAnd);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 24'd0, 5'd5);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, iJunk, 5'd0);
        checkOutput("halt slot0", {slotObs, fetchBus.pc}, {vec(iAdd), 5'd1});
        idle();
        checkOutput("halt slot1", {slotObs, fetchBus.pc}, {vec(iSub), 5'd2});
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 24'd0, 5'd0);
        checkOutput("halt bubble", {slotObs, fetchBus.busy, fetchBus.pc}, {BUB, 1'b1, 5'd2});
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput($sformatf("halt drain%0d", i), {slotObs, fetchBus.done, fetchBus.pc},
                        {BUB, 1'b0, 5'd2});
        end
        idle();
        checkOutput("halt done", {fetchBus.done, fetchBus.busy, fetchBus.pc}, {1'b1, 1'b0, 5'd2});
        runProgram("rerun5", 5'd5, '{vec(iAdd), vec(iSub), vec(iOr), vec(iXor), vec(iAnd),
                                     BUB, BUB, BUB});

        $display("[TB] start with halt from idle");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 24'd0, 5'd5);
        checkOutput("start+halt", {slotObs, fetchBus.busy}, {BUB, 1'b0});
        idle();
        checkOutput("start+halt later", {31'd0, fetchBus.busy}, 32'd0);

        $display("[TB] empty program");
        runProgram("empty", 5'd0, '{BUB, BUB, BUB});

        $display("[TB] async reset mid-run");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 24'd0, 5'd5);
        idle();
        idle();
        checkOutput("pre-reset slot", {slotObs, fetchBus.pc}, {vec(iSub), 5'd2});
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset", {slotObs, fetchBus.busy, fetchBus.done, fetchBus.pc},
                    {BUB, 1'b0, 1'b0, 5'd0});
        #2 rst_n = 1'b1;
        runProgram("post-reset", 5'd5, '{vec(iAdd), vec(iSub), vec(iOr), vec(iXor), vec(iAnd),
                                         BUB, BUB, BUB});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_fetch.md
# pipe_fetch

Instruction fetch and issue stage placed directly upstream of the four-stage register-read / ALU / writeback / store pipeline. It holds a small loadable program buffer and steps a program counter through it. Each cycle it drives one decoded instruction onto the pipeline's `rs1`/`rs2`/`rd`/`func`/`addr` inputs. Because the downstream pipeline has no forwarding and no valid bit, this block detects read-after-write hazards itself and issues harmless NOP bubbles when a hazard is found.

## Interface
- `IMEM_DEPTH`, 16: number of program buffer entries, in 24-bit words.
- `NOP_RD`, 4'd0: register used as source and destination of a bubble.
- `NOP_ADDR`, 8'hFF: scratch data-memory address that bubbles store to. It is reserved and programs must not use it.
- `clk` in 1: the single clock, connected to the downstream `clk1`.
- `rst_n` in 1: reset, asynchronous and active-low.
- `load_en` in 1: write `load_data` into the buffer at `load_addr`. Accepted only in IDLE or DONE.
- `load_addr` in 4: program buffer write index.
- `load_data` in 24: instruction word with fields {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}.
- `prog_len` in 5: instruction count, 0..IMEM_DEPTH. Sampled on `start`.
- `start` in 1: one-cycle pulse that begins execution at PC 0. Ignored while busy.
- `halt` in 1: stop issuing real instructions and drain.
- `rs1`, `rs2`, `rd`, `func` out 4 each: registered fields driven to the downstream pipeline.
- `addr` out 8: registered store address.
- `issue_valid` out 1: high when the current output slot is a real instruction, low when it is a bubble.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at the end of DRAIN.
- `pc` out 5: current program counter.

## Operation
- Bubble encoding: func=3 (pass A), rs1=rd=NOP_RD, rs2=0, addr=NOP_ADDR, issue_valid=0. It rewrites NOP_RD with its own value, so register state is unchanged.
- Reset values: all field outputs hold the bubble encoding; issue_valid=0, busy=0, done=0, pc=0; FSM in IDLE; hazard tracker cleared.
- FSM states and transitions:
  - IDLE: on `start`, load prog_len. If prog_len=0 go to DRAIN, otherwise go to RUN with pc=0.
  - RUN: each cycle, issue buffer[pc] and increment pc, or issue a bubble on a hazard.
    - When pc reaches prog_len after an issue, go to DRAIN.
    - A fetched func=15 is the HALT opcode. It is not issued; a bubble goes out instead and the FSM goes to DRAIN.
    - `halt` high: a bubble is issued that cycle, pc freezes, and the FSM goes to DRAIN.
  - DRAIN: issue exactly 3 bubbles, then go to DONE with `done` pulsed.
  - DONE: behaves as IDLE; `start` restarts the program.
- Source usage by func:
  - func 0, 1, 2, 5, 6, 7 read rs1 and rs2.
  - func 3, 8, 10, 11 read rs1 only.
  - func 4, 9 read rs2 only.
  - func 12..14 read no register.
- Hazard rule: the candidate instruction stalls when a source it reads equals the `rd` of the previous slot and that slot had issue_valid=1.
  - On a stall, issue one bubble and hold pc. The candidate issues in the next cycle.
  - Only the immediately previous slot is checked; a gap of one slot is sufficient.
- The pc width is 5 bits, so no wrap-around can occur; pc never exceeds prog_len.
- `load_en` while busy is ignored, leaving the buffer unchanged.
- `start` and `halt` asserted in the same cycle from IDLE: `start` is ignored.

## Timing
- The output fields update on posedge clk and are sampled by the downstream pipeline at the next posedge.
- A slot issued at edge k is read at k+1 and written back at k+2, so a consumer is legal from k+2 onward.
- Latency from `start` to the first instruction on the outputs: 1 cycle.
- A hazard-free program of N instructions takes N+3 cycles from the first issue to the `done` pulse.
- Asserting `rst_n` low mid-run takes effect immediately: outputs return to the bubble encoding and the FSM returns to IDLE. Buffer contents are retained.

## Configuration
- `PIPE_FETCH_STATS_EN`
  - Defined: adds output `stall_cnt` (8 bits), which counts hazard bubbles. It saturates at 255, clears on `start`, and resets to 0.
  - Undefined: the port and counter are absent and functional behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - instruction field positions
  - func opcode constants (ADD=0 … SHL=11, HALT=15)
  - FSM state enum
  - the bubble encoding
  - function `uses_rs1`/`uses_rs2`
- Sub-module `pipe_hazard_chk`: combinational comparison of the candidate's sources against the previous slot's rd and valid bit. The FSM and buffer live in `pipe_fetch`.

## Test plan
- Program {ADD r3=r1+r2, SUB r4=r5-r6}, prog_len=2: two issues with issue_valid=1, then 3 bubbles, then `done` at cycle 5 after the first issue.
- Program {ADD r3=r1+r2, MOV r7=r3 (func 3)}: the sequence is ADD, bubble, MOV; with stats enabled `stall_cnt`=1.
- Program {ADD r3, SHL r8=r2<<1 with rs2=3}: no stall, because func 11 does not read rs2.
- Program {ADD, HALT, SUB}, prog_len=3: ADD issues, then 4 bubbles; SUB is never issued; `done` pulses.
- `halt` asserted in cycle 2 of a 5-instruction run: pc frozen at 2, 3 drain bubbles, `done`. `load_en` during the run leaves the buffer unchanged.
- `rst_n` asserted low during RUN: outputs are the bubble encoding (func=3, addr=8'hFF) asynchronously. A subsequent `start` reruns the retained program from pc=0.
